// File: rtl/lcd_8080_tx_pkg.sv
// Shared types for the 8080-style LCD write transmitter: FSM states,
// the queued byte format and the LCD command opcodes used by the init logic.
package lcd_tx_pkg;

    typedef enum logic [2:0] {
        RST_LOW, RST_WAIT, IDLE, WR_LOW, WR_HIGH, FILL_LOW, FILL_HIGH
    } lcd_state_e;

    typedef struct packed {
        logic       dc;
        logic [7:0] data;
    } lcd_byte_t;

    localparam logic [7:0] SWRESET = 8'h01;
    localparam logic [7:0] SLPOUT  = 8'h11;
    localparam logic [7:0] DISPON  = 8'h29;
    localparam logic [7:0] CASET   = 8'h2A;
    localparam logic [7:0] PASET   = 8'h2B;
    localparam logic [7:0] RAMWR   = 8'h2C;

    // Largest of the phase lengths; sizes the shared phase counter.
    function automatic int max4(input int a, input int b, input int c, input int d);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        if (d > m) m = d;
        return m;
    endfunction

endpackage

// File: rtl/lcd_8080_tx_if.sv
// Byte stream into the LCD transmitter: valid/ready with a d/c flag.
interface lcd_8080_tx_if;
    logic       in_valid;
    logic       in_ready;
    logic       in_dc;
    logic [7:0] in_data;

    modport master (output in_valid, output in_dc, output in_data, input in_ready);
    modport slave  (input in_valid, input in_dc, input in_data, output in_ready);
endinterface

// File: rtl/lcd_8080_tx_fifo.sv
// Small synchronous FIFO of lcd_byte_t. Push while full and pop while
// empty are ignored; pointers wrap naturally since DEPTH is a power of two.
module lcd_tx_fifo import lcd_tx_pkg::*; #(
    parameter int DEPTH = 8
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   push_i,
    input  lcd_byte_t              wdata_i,
    input  logic                   pop_i,
    output lcd_byte_t              rdata_o,
    output logic [$clog2(DEPTH):0] count_o,
    output logic                   full_o,
    output logic                   empty_o
);
    localparam int AW = $clog2(DEPTH);

    lcd_byte_t      mem_q [DEPTH];
    logic [AW-1:0]  wp_q, rp_q;
    logic [AW:0]    cnt_q;
    logic           do_push, do_pop;

    assign full_o  = (cnt_q == (AW+1)'(DEPTH));
    assign empty_o = (cnt_q == '0);
    assign count_o = cnt_q;
    assign rdata_o = mem_q[rp_q];
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;

    // Storage write; contents need no reset since count gates reads.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wp_q] <= wdata_i;
    end

    // Pointer and occupancy update.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wp_q  <= '0;
            rp_q  <= '0;
            cnt_q <= '0;
        end else begin
            if (do_push) wp_q <= wp_q + AW'(1);
            if (do_pop)  rp_q <= rp_q + AW'(1);
            case ({do_push, do_pop})
                2'b10:   cnt_q <= cnt_q + (AW+1)'(1);
                2'b01:   cnt_q <= cnt_q - (AW+1)'(1);
                default: cnt_q <= cnt_q;
            endcase
        end
    end
endmodule

// File: rtl/lcd_8080_tx.sv
// 8080 parallel write transmitter: runs the LCD hardware-reset sequence,
// then drains the byte FIFO onto lcd_db with programmable WR low/high phases.
// Optional solid-colour fill engine enabled by defining LCD_TX_FILL_EN.
module lcd_8080_tx import lcd_tx_pkg::*; #(
    parameter int FIFO_DEPTH      = 8,
    parameter int WR_LOW_CYCLES   = 2,
    parameter int WR_HIGH_CYCLES  = 2,
    parameter int RST_LOW_CYCLES  = 250,
    parameter int RST_WAIT_CYCLES = 3000
) (
    input  logic                        clk,
    input  logic                        reset,
    lcd_8080_tx_if.slave                s_if,
    output logic                        busy,
    output logic [$clog2(FIFO_DEPTH):0] fifo_count,
    output logic [7:0]                  lcd_db,
    output logic                        lcd_d_c,
    output logic                        lcd_wr,
    output logic                        lcd_rd,
    output logic                        lcd_reset
`ifdef LCD_TX_FILL_EN
    ,
    input  logic                        fill_start,
    input  logic [15:0]                 fill_color,
    input  logic [16:0]                 fill_pixels,
    output logic                        fill_done
`endif
);
    localparam int CW = $clog2(max4(WR_LOW_CYCLES, WR_HIGH_CYCLES,
                                    RST_LOW_CYCLES, RST_WAIT_CYCLES) + 1);

    lcd_state_e    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    lcd_byte_t     bus_q, bus_d;
    logic          wr_q, wr_d, lrst_q, lrst_d;
    logic          push, pop, full, empty, init_done, filling;
    lcd_byte_t     head;

`ifdef LCD_TX_FILL_EN
    logic [16:0]   pix_q, pix_d;
    logic [15:0]   col_q, col_d;
    logic          lo_q, lo_d, done_q, done_d;
    assign filling   = (state_q == FILL_LOW) || (state_q == FILL_HIGH);
    assign fill_done = done_q;
`else
    assign filling   = 1'b0;
`endif

    assign init_done     = (state_q != RST_LOW) && (state_q != RST_WAIT);
    assign s_if.in_ready = init_done && !full && !filling;
    assign push          = s_if.in_valid && s_if.in_ready;
    assign busy          = (state_q != IDLE) || (fifo_count != '0);
    assign lcd_db        = bus_q.data;
    assign lcd_d_c       = bus_q.dc;
    assign lcd_wr        = wr_q;
    assign lcd_rd        = 1'b1;
    assign lcd_reset     = lrst_q;

    lcd_tx_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .push_i  (push),
        .wdata_i ({s_if.in_dc, s_if.in_data}),
        .pop_i   (pop),
        .rdata_o (head),
        .count_o (fifo_count),
        .full_o  (full),
        .empty_o (empty)
    );

    // Next state, phase counter, bus load and strobe level; wr_d is the
    // strobe level for the next cycle so lcd_wr falls with the bus update.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + CW'(1);
        bus_d   = bus_q;
        wr_d    = 1'b1;
        lrst_d  = lrst_q;
        pop     = 1'b0;
`ifdef LCD_TX_FILL_EN
        pix_d   = pix_q;
        col_d   = col_q;
        lo_d    = lo_q;
        done_d  = 1'b0;
`endif
        case (state_q)
            RST_LOW: begin
                lrst_d = 1'b0;
                if (cnt_q == CW'(RST_LOW_CYCLES - 1)) begin
                    state_d = RST_WAIT;
                    cnt_d   = '0;
                    lrst_d  = 1'b1;
                end
            end
            RST_WAIT: begin
                if (cnt_q == CW'(RST_WAIT_CYCLES - 1)) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end
            end
            IDLE: begin
                cnt_d = '0;
                if (!empty) begin
                    pop     = 1'b1;
                    bus_d   = head;
                    wr_d    = 1'b0;
                    state_d = WR_LOW;
                end
`ifdef LCD_TX_FILL_EN
                else if (fill_start) begin
                    if (fill_pixels == '0) begin
                        done_d = 1'b1;
                    end else begin
                        bus_d   = {1'b1, fill_color[15:8]};
                        col_d   = fill_color;
                        pix_d   = fill_pixels;
                        lo_d    = 1'b0;
                        wr_d    = 1'b0;
                        state_d = FILL_LOW;
                    end
                end
`endif
            end
            WR_LOW: begin
                wr_d = 1'b0;
                if (cnt_q == CW'(WR_LOW_CYCLES - 1)) begin
                    wr_d    = 1'b1;
                    cnt_d   = '0;
                    state_d = WR_HIGH;
                end
            end
            WR_HIGH: begin
                if (cnt_q == CW'(WR_HIGH_CYCLES - 1)) begin
                    cnt_d = '0;
                    if (!empty) begin
                        pop     = 1'b1;
                        bus_d   = head;
                        wr_d    = 1'b0;
                        state_d = WR_LOW;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
`ifdef LCD_TX_FILL_EN
            FILL_LOW: begin
                wr_d = 1'b0;
                if (cnt_q == CW'(WR_LOW_CYCLES - 1)) begin
                    wr_d    = 1'b1;
                    cnt_d   = '0;
                    state_d = FILL_HIGH;
                end
            end
            FILL_HIGH: begin
                if (cnt_q == CW'(WR_HIGH_CYCLES - 1)) begin
                    cnt_d = '0;
                    if (!lo_q) begin
                        bus_d   = {1'b1, col_q[7:0]};
                        lo_d    = 1'b1;
                        wr_d    = 1'b0;
                        state_d = FILL_LOW;
                    end else if (pix_q == 17'd1) begin
                        done_d  = 1'b1;
                        state_d = IDLE;
                    end else begin
                        bus_d   = {1'b1, col_q[15:8]};
                        pix_d   = pix_q - 17'd1;
                        lo_d    = 1'b0;
                        wr_d    = 1'b0;
                        state_d = FILL_LOW;
                    end
                end
            end
`endif
            default: begin
                state_d = RST_LOW;
                cnt_d   = '0;
            end
        endcase
    end

    // State and registered LCD pins; reset restarts the full LCD init.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= RST_LOW;
            cnt_q   <= '0;
            bus_q   <= '0;
            wr_q    <= 1'b1;
            lrst_q  <= 1'b0;
`ifdef LCD_TX_FILL_EN
            pix_q   <= '0;
            col_q   <= '0;
            lo_q    <= 1'b0;
            done_q  <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bus_q   <= bus_d;
            wr_q    <= wr_d;
            lrst_q  <= lrst_d;
`ifdef LCD_TX_FILL_EN
            pix_q   <= pix_d;
            col_q   <= col_d;
            lo_q    <= lo_d;
            done_q  <= done_d;
`endif
        end
    end
endmodule
